// File: rtl/echo_scheduler.sv
// echo_scheduler: TUSS burst -> blank -> listen -> gap sequencer with an echo
// streak counter driving the active-low ct LED and a latched burst-timeout fault.
module echo_scheduler #(
    parameter int unsigned BLANK_CYCLES  = 500,
    parameter int unsigned LISTEN_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES    = 100,
    parameter int unsigned BURST_TIMEOUT = 20000,
    parameter int unsigned HITS_NEEDED   = 5,
    parameter int unsigned MAX_FAULTS    = 3,
    parameter int unsigned CNT_W         = 17
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tuss_ready,
    input  logic       burst_finish,
    input  logic       out_3,
    output logic       burst_en,
    output logic       burst_rstn,
    output logic       listen_en,
    output logic       echo_hit,
    output logic [3:0] hit_cnt,
    output logic       ct,
    output logic       fault,
    output logic [2:0] state
);
    localparam int unsigned HIT_W = 4;
    localparam int unsigned FLT_W = $clog2(MAX_FAULTS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_BURST    = 3'd2,
        S_BLANK    = 3'd3,
        S_LISTEN   = 3'd4,
        S_GAP      = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic [FLT_W-1:0] r_fault_cnt, w_fault_cnt_nxt, w_fault_inc;
    logic [HIT_W-1:0] r_streak, w_streak_nxt, w_streak_inc;
    logic             r_win_hit, w_win_hit_nxt;
    logic             w_echo_hit_nxt, w_burst_rstn_nxt;
    logic             r_sync1, r_sync2, r_prev;
    logic             w_edge;

    // Rising edge of the synchronized comparator; r_prev tracks every cycle.
    assign w_edge       = r_sync2 & ~r_prev;
    assign w_fault_inc  = r_fault_cnt + FLT_W'(1);
    assign w_streak_inc = (r_streak < HIT_W'(HITS_NEEDED)) ? r_streak + HIT_W'(1) : r_streak;
    assign hit_cnt      = r_streak;
    assign state        = r_state;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_fault_cnt <= '0;
            r_streak    <= '0;
            r_win_hit   <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            burst_en    <= 1'b0;
            burst_rstn  <= 1'b1;
            listen_en   <= 1'b0;
            echo_hit    <= 1'b0;
            ct          <= 1'b1;
            fault       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_fault_cnt <= w_fault_cnt_nxt;
            r_streak    <= w_streak_nxt;
            r_win_hit   <= w_win_hit_nxt;
            r_sync1     <= out_3;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            burst_en    <= (w_state_nxt == S_BURST);
            burst_rstn  <= w_burst_rstn_nxt;
            listen_en   <= (w_state_nxt == S_LISTEN);
            echo_hit    <= w_echo_hit_nxt;
            ct          <= (w_streak_nxt != HIT_W'(HITS_NEEDED));
            fault       <= (w_state_nxt == S_FAULT);
        end
    end

    // Next-state, timer, streak and fault-counter logic; enable low overrides all.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer + CNT_W'(1);
        w_fault_cnt_nxt  = r_fault_cnt;
        w_streak_nxt     = r_streak;
        w_win_hit_nxt    = r_win_hit;
        w_echo_hit_nxt   = 1'b0;
        w_burst_rstn_nxt = 1'b1;
        if (!enable) begin
            w_state_nxt     = S_IDLE;
            w_timer_nxt     = '0;
            w_fault_cnt_nxt = '0;
            w_streak_nxt    = '0;
            w_win_hit_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    w_timer_nxt = '0;
                    if (tuss_ready) w_state_nxt = S_BURST;
                end
                S_BURST: begin
                    if (burst_finish) begin
                        w_state_nxt      = S_BLANK;
                        w_timer_nxt      = '0;
                        w_burst_rstn_nxt = 1'b0;
                        w_fault_cnt_nxt  = '0;
                    end else if (r_timer == CNT_W'(BURST_TIMEOUT - 1)) begin
                        w_timer_nxt     = '0;
                        w_fault_cnt_nxt = w_fault_inc;
                        w_state_nxt     = (w_fault_inc == FLT_W'(MAX_FAULTS)) ? S_FAULT : S_GAP;
                    end
                end
                S_BLANK: begin
                    if (r_timer == CNT_W'(BLANK_CYCLES - 1)) begin
                        w_state_nxt   = S_LISTEN;
                        w_timer_nxt   = '0;
                        w_win_hit_nxt = 1'b0;
                    end
                end
                S_LISTEN: begin
                    if (w_edge && !r_win_hit) begin
                        w_echo_hit_nxt = 1'b1;
                        w_win_hit_nxt  = 1'b1;
                    end
                    // An edge landing in the final cycle still scores this window.
                    if (r_timer == CNT_W'(LISTEN_CYCLES - 1)) begin
                        w_state_nxt   = S_GAP;
                        w_timer_nxt   = '0;
                        w_win_hit_nxt = 1'b0;
                        w_streak_nxt  = (r_win_hit || w_edge) ? w_streak_inc : '0;
                    end
                end
                S_GAP: begin
                    if (r_timer == CNT_W'(GAP_CYCLES - 1)) begin
                        w_state_nxt = S_WAIT_RDY;
                        w_timer_nxt = '0;
                    end
                end
                S_FAULT: begin
                    w_timer_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_echo_scheduler.sv
// Bench for echo_scheduler: directed and randomized burst/echo scenarios scored
// against a window-level reference model of the echo streak and timing.
module tb_echo_scheduler;
    localparam int B    = 20;
    localparam int L    = 60;
    localparam int G    = 10;
    localparam int TO   = 40;
    localparam int H    = 5;
    localparam int MF   = 3;
    localparam int HIST = 32768;

    logic       gclk, rst, enable, tuss_ready, burst_finish, out_3;
    logic       burst_en, burst_rstn, listen_en, echo_hit, ct, fault;
    logic [3:0] hit_cnt;
    logic [2:0] state;

    int n_checks, n_pass, edge_n, exp_streak, exp_flt;
    bit x_hist [HIST];

    echo_scheduler #(
        .BLANK_CYCLES(B), .LISTEN_CYCLES(L), .GAP_CYCLES(G), .BURST_TIMEOUT(TO),
        .HITS_NEEDED(H), .MAX_FAULTS(MF), .CNT_W(17)
    ) dut (
        .gclk(gclk), .rst(rst), .enable(enable), .tuss_ready(tuss_ready),
        .burst_finish(burst_finish), .out_3(out_3), .burst_en(burst_en),
        .burst_rstn(burst_rstn), .listen_en(listen_en), .echo_hit(echo_hit),
        .hit_cnt(hit_cnt), .ct(ct), .fault(fault), .state(state)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock edge; records the out_3 level the DUT sampled at that edge.
    task automatic tick();
        @(posedge gclk);
        edge_n++;
        if (edge_n < HIST) x_hist[edge_n] = out_3;
        #1;
    endtask

    function automatic logic pulse_at(input int d, input int s, input int l);
        return (l > 0) && (d >= s) && (d < s + l);
    endfunction

    // One burst with prompt finish; out_3 pulses are placed relative to the finish edge.
    task automatic run_burst(input int fin_d, input int a_s, input int a_l, input int b_s,
                             input int b_l, input bit stray, input int abort_d, input int rdy_gap);
        int w, blen, n0, lis_first, lis_len, e_cnt, e_d, obs_hits, obs_ct, obs_state, exp_e;
        bit hit;
        w = 0;
        while (!burst_en && w < 300) begin tick(); w++; end
        check("burst_start", burst_en, 1);
        if (!burst_en) return;
        blen = 0;
        for (int i = 0; i < fin_d; i++) begin
            blen += int'(burst_en);
            if (i == fin_d - 1) burst_finish = 1'b1;
            tick();
            burst_finish = 1'b0;
        end
        n0 = edge_n;
        exp_flt = 0;
        check("burst_len", blen, fin_d);
        check("fin_burst_en", burst_en, 0);
        check("fin_rstn_lo", burst_rstn, 0);
        check("fin_state", state, 3);
        lis_first = -1; lis_len = 0; e_cnt = 0; e_d = -1;
        obs_hits = -1; obs_ct = -1; obs_state = -1;
        for (int d = 1; d <= B + L + 3; d++) begin
            out_3 = pulse_at(d, a_s, a_l) || pulse_at(d, b_s, b_l);
            if (stray && d == B + 5) burst_finish = 1'b1;
            if (abort_d == d) enable = 1'b0;
            tick();
            burst_finish = 1'b0;
            if (abort_d == d) begin
                check("abort_state", state, 0);
                check("abort_hits", hit_cnt, 0);
                check("abort_listen", listen_en, 0);
                check("abort_ct", ct, 1);
                out_3 = 1'b0;
                exp_streak = 0;
                exp_flt = 0;
                return;
            end
            if (abort_d == d + 1) check("pre_abort_hits", hit_cnt, exp_streak);
            if (d == 1) check("rstn_hi", burst_rstn, 1);
            if (listen_en) begin lis_len++; if (lis_first < 0) lis_first = d; end
            if (echo_hit) begin e_cnt++; if (e_d < 0) e_d = d; end
            if (d == B + L) begin obs_hits = hit_cnt; obs_ct = ct; obs_state = state; end
        end
        out_3 = 1'b0;
        // Model: window covers edges n0+B .. n0+B+L-1; echo seen two edges after sampling.
        exp_e = -1;
        for (int e = n0 + B; e <= n0 + B + L - 1; e++)
            if (exp_e < 0 && x_hist[e - 1] && !x_hist[e - 2]) exp_e = e;
        hit = (exp_e >= 0);
        exp_streak = hit ? ((exp_streak < H) ? exp_streak + 1 : H) : 0;
        check("listen_start", lis_first, B);
        check("listen_len", lis_len, L);
        check("echo_cnt", e_cnt, hit ? 1 : 0);
        if (hit) check("echo_lat", e_d, exp_e + 1 - n0);
        check("hit_cnt", obs_hits, exp_streak);
        check("ct", obs_ct, (exp_streak == H) ? 0 : 1);
        check("gap_state", obs_state, 5);
        w = B + L + 3;
        while (!burst_en && w < B + L + G + 40) begin
            tuss_ready = (w + 1 >= B + L + G + 1 + rdy_gap);
            tick(); w++;
        end
        tuss_ready = 1'b1;
        check("period", w, B + L + G + 1 + rdy_gap);
    endtask

    task automatic measure_timeout();
        int w, blen;
        bit exp_fault;
        w = 0;
        while (!burst_en && w < 300) begin tick(); w++; end
        check("to_start", burst_en, 1);
        blen = 0;
        while (burst_en && blen < 3 * TO) begin blen++; tick(); end
        exp_flt++;
        exp_fault = (exp_flt == MF);
        check("to_len", blen, TO);
        check("to_state", state, exp_fault ? 6 : 5);
        check("to_fault", fault, int'(exp_fault));
        check("to_hits", hit_cnt, exp_streak);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd, as, al, bs, bl, w;
        n_checks = 0; n_pass = 0; edge_n = 0; exp_streak = 0; exp_flt = 0;
        gclk = 1'b0; rst = 1'b1; enable = 1'b0; tuss_ready = 1'b0;
        burst_finish = 1'b0; out_3 = 1'b0;
        #12;
        check("rst_burst_en", burst_en, 0);
        check("rst_burst_rstn", burst_rstn, 1);
        check("rst_listen_en", listen_en, 0);
        check("rst_echo_hit", echo_hit, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_ct", ct, 1);
        check("rst_fault", fault, 0);
        check("rst_state", state, 0);
        tick();
        rst = 1'b0; enable = 1'b1; tuss_ready = 1'b1;

        // Five echo windows build the streak; a silent sixth clears it.
        run_burst(10, B + 10, 3, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) run_burst(6, B + 10 + i * 7, 3, 0, 0, 1'b0, 0, 0);
        run_burst(7, 0, 0, 0, 0, 1'b0, 0, 0);
        // Blank pulse and level held across listen entry score no hit.
        run_burst(5, B + 10, 2, 0, 0, 1'b0, 0, 0);
        run_burst(5, 3, 2, B - 4, 20, 1'b0, 0, 0);
        // Two pulses in one window, and window-boundary pulses.
        run_burst(4, B + 5, 3, B + 20, 3, 1'b0, 0, 0);
        run_burst(3, B + L - 2, 2, 0, 0, 1'b1, 0, 1);
        run_burst(3, B + L - 1, 2, 0, 0, 1'b0, 0, 0);
        run_burst(3, B - 1, 2, 0, 0, 1'b0, 0, 2);
        run_burst(3, B - 2, 2, 0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            fd = int'($urandom_range(1, 15));
            as = int'($urandom_range(B - 3, B + L));
            al = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3));
            bs = as + al + 1 + int'($urandom_range(0, 10));
            bl = int'($urandom_range(0, 3));
            if (bs + bl - 1 > B + L + 3) bl = 0;
            run_burst(fd, as, al, bs, bl, 1'($urandom_range(0, 1)), 0, int'($urandom_range(0, 3)));
        end

        // Drop enable mid-listen with a streak of three.
        enable = 1'b0; tick();
        check("dis_state", state, 0);
        check("dis_hits", hit_cnt, 0);
        exp_streak = 0; exp_flt = 0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) run_burst(6, B + 8, 2, 0, 0, 1'b0, 0, 0);
        run_burst(6, B + 5, 2, 0, 0, 1'b0, B + 30, 0);
        tick();
        enable = 1'b1;

        // Timeouts: a finished burst clears the fault count; three in a row latch fault.
        run_burst(8, B + 12, 2, 0, 0, 1'b0, 0, 0);
        measure_timeout();
        measure_timeout();
        run_burst(8, B + 12, 2, 0, 0, 1'b0, 0, 0);
        measure_timeout();
        measure_timeout();
        measure_timeout();
        repeat (5) tick();
        check("fault_hold", fault, 1);
        check("fault_state", state, 6);
        enable = 1'b0; tick();
        check("fault_clr_state", state, 0);
        check("fault_clr", fault, 0);
        check("fault_clr_hits", hit_cnt, 0);
        check("fault_clr_ct", ct, 1);
        exp_streak = 0; exp_flt = 0;

        // Asynchronous reset in the middle of a burst.
        enable = 1'b1;
        w = 0;
        while (!burst_en && w < 50) begin tick(); w++; end
        check("pre_rst_burst", burst_en, 1);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("arst_burst_en", burst_en, 0);
        check("arst_state", state, 0);
        check("arst_rstn", burst_rstn, 1);
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/echo_scheduler.md
# echo_scheduler

Synthesizable burst/listen sequencer for the TUSS ultrasonic front end. It waits for chip ready and fires a burst through `burst_en`/`burst_finish`. It then blanks transducer ringing and opens a timed listen window on `out_3`. It counts consecutive echo hits and drives the `ct` LED once `HITS_NEEDED` consecutive bursts return an echo. It sits between the TUSS burst/IO logic and the LED/status outputs, and supervises burst timeouts with a fault latch.

## Interface
- `BLANK_CYCLES`, 500: cycles after burst completion during which `out_3` is ignored (ringing).
- `LISTEN_CYCLES`, 50000: listen window length in cycles.
- `GAP_CYCLES`, 100: idle cycles between listen end and next burst.
- `BURST_TIMEOUT`, 20000: max cycles in BURST waiting for `burst_finish`.
- `HITS_NEEDED`, 5: consecutive hits required to set object_found.
- `MAX_FAULTS`, 3: consecutive burst timeouts that latch FAULT.
- `CNT_W`, 17: width of the shared cycle timer; must hold the largest cycle parameter.
- `gclk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; low forces IDLE.
- `tuss_ready` in 1: TUSS configured and ready.
- `burst_finish` in 1: single-cycle pulse, burst complete.
- `out_3` in 1: asynchronous echo comparator output.
- `burst_en` out 1: burst request, high throughout BURST.
- `burst_rstn` out 1: active-low burst logic reset, one-cycle low pulse.
- `listen_en` out 1: high throughout LISTEN.
- `echo_hit` out 1: one-cycle pulse on first echo in a window.
- `hit_cnt` out 4: current consecutive-hit streak, saturating at HITS_NEEDED.
- `ct` out 1: LED drive, active low; 0 = object found.
- `fault` out 1: burst-timeout fault latched.
- `state` out 3: FSM state encoding (debug).

## Operation
- States: IDLE=0, WAIT_RDY=1, BURST=2, BLANK=3, LISTEN=4, GAP=5, FAULT=6.
- IDLE: `enable`=1 -> WAIT_RDY.
- WAIT_RDY: `tuss_ready`=1 -> BURST, timer cleared. `tuss_ready` is sampled only in this state.
- BURST: `burst_en`=1.
  - `burst_finish`=1 -> BLANK; `burst_rstn`=0 for the next cycle; fault counter cleared.
  - Timer reaches BURST_TIMEOUT-1 without finish -> fault counter +1. If the new count equals MAX_FAULTS -> FAULT, else -> GAP. Streak is unchanged on a timeout.
- BLANK: exactly BLANK_CYCLES cycles -> LISTEN. Echo edges are discarded.
- LISTEN: exactly LISTEN_CYCLES cycles; `listen_en`=1.
  - The first synchronized rising edge of `out_3` pulses `echo_hit` and sets the window-hit flag. Later edges in the same window are ignored.
  - At window end: hit -> streak +1, saturating; miss -> streak=0. Then -> GAP.
- GAP: exactly GAP_CYCLES cycles -> WAIT_RDY.
- FAULT: `fault`=1; holds until `enable`=0 (-> IDLE, `fault` cleared) or `rst`.
- `enable`=0 in any state -> IDLE next cycle. Timer, streak, fault counter and window flag are cleared. `ct` returns to 1.
- `ct`=0 while streak == HITS_NEEDED. The first miss clears the streak, so `ct`=1.
- `out_3` passes a 2-flop synchronizer, then a previous-value register for edge detection. The previous-value register updates every cycle, so a level already high at LISTEN entry is not a hit.

## Timing
- Reset values: `burst_en`=0, `burst_rstn`=1, `listen_en`=0, `echo_hit`=0, `hit_cnt`=0, `ct`=1, `fault`=0, `state`=IDLE. All counters are 0.
- All outputs are registered and change on `gclk` rising edge.
- `out_3` rise to `echo_hit` latency: 3 cycles. A rise whose synchronized edge lands in the last LISTEN cycle counts.
- `burst_finish` sampled at edge N: `burst_en` low and `burst_rstn` low at N+1, `burst_rstn` high at N+2.
- `burst_finish` outside BURST is ignored.
- `hit_cnt`/`ct` update on the cycle after the last LISTEN cycle.
- Burst period with prompt finish: WAIT_RDY(>=1) + BURST(k) + BLANK_CYCLES + LISTEN_CYCLES + GAP_CYCLES.
- `rst` mid-operation: immediate asynchronous return to reset values.

## Test plan
- Reset, `enable`=1, `tuss_ready`=1, `burst_finish` 10 cycles after `burst_en` rises -> one-cycle `burst_rstn`=0. `listen_en` rises exactly BLANK_CYCLES cycles later and stays high exactly LISTEN_CYCLES cycles.
- Echo each window for 5 bursts -> `hit_cnt` goes 1..5 and `ct`=0 after the 5th window. A 6th window without echo -> `hit_cnt`=0, `ct`=1.
- `out_3` pulse during BLANK, plus `out_3` held high across LISTEN entry -> no `echo_hit`; `hit_cnt` cleared at window end.
- Two `out_3` pulses in one window -> exactly one `echo_hit`; `hit_cnt` +1.
- `burst_finish` never asserted -> three timeouts of BURST_TIMEOUT cycles each, then `fault`=1 and `state`=6. `enable`=0 -> IDLE and `fault`=0.
- `enable` dropped mid-LISTEN with `hit_cnt`=3 -> IDLE next cycle, `hit_cnt`=0, `listen_en`=0. Async `rst` mid-BURST -> `burst_en`=0 immediately.
